// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
// The master side presents operands and consumes results; the slave side
// is the adder itself. The ovf signal exists only when CLA_OVF_EN is defined.
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CLA_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout
`ifdef CLA_OVF_EN
    , ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout
`ifdef CLA_OVF_EN
    , ovf
`endif
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor.
// Stage 1 adds the lower half and registers the carry into the upper half
// together with the upper operand bits; stage 2 adds the upper half.
// Valid/ready handshake on both sides with bubble collapsing.
// Optional macro CLA_OVF_EN adds the registered signed-overflow output ovf.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  pipelined_cla_adder_if.slave  bus
);

  localparam int H  = WIDTH / 2;
  localparam int NG = H / GROUP;

  // Operand conditioning: subtraction is A + ~B + 1
  logic [WIDTH-1:0] bx;
  logic             c0;

  assign bx = bus.sub ? ~bus.b : bus.b;
  assign c0 = bus.sub | bus.cin;

  // Pipeline registers
  logic             vld_p1;
  logic [H-1:0]     sum_lo_p1;
  logic             c_mid_p1;
  logic [H-1:0]     a_hi_p1;
  logic [H-1:0]     b_hi_p1;

  logic             vld_p2;
  logic [WIDTH-1:0] sum_p2;
  logic             cout_p2;

  // Half-width CLA inputs/outputs: index 0 = lower half (stage 1),
  // index 1 = upper half (stage 2). Both use the same lookahead structure.
  logic [H-1:0] hx  [2];
  logic [H-1:0] hy  [2];
  logic         hci [2];
  logic [H-1:0] hs  [2];
  logic         hco [2];

  assign hx[0]  = bus.a[H-1:0];
  assign hy[0]  = bx[H-1:0];
  assign hci[0] = c0;

  assign hx[1]  = a_hi_p1;
  assign hy[1]  = b_hi_p1;
  assign hci[1] = c_mid_p1;

  for (genvar h = 0; h < 2; h++) begin : g_half
    logic [H-1:0]  g;
    logic [H-1:0]  p;
    logic [H-1:0]  c;   // carry into each bit
    logic [NG-1:0] gg;  // group generate
    logic [NG-1:0] gp;  // group propagate
    logic [NG:0]   gc;  // carry into each group, gc[NG] is the half carry-out

    assign g = hx[h] & hy[h];
    assign p = hx[h] ^ hy[h];

    for (genvar k = 0; k < NG; k++) begin : g_grp
      logic [GROUP-1:0] rc;  // in-group carries seeded by the group carry-in
      logic [GROUP:0]   rg;  // in-group generate prefix, carry-in forced to 0

      assign rc[0] = gc[k];
      assign rg[0] = 1'b0;

      for (genvar i = 0; i < GROUP; i++) begin : g_bit
        if (i < GROUP - 1) begin : g_rc
          assign rc[i+1] = g[k*GROUP+i] | (p[k*GROUP+i] & rc[i]);
        end
        assign rg[i+1]      = g[k*GROUP+i] | (p[k*GROUP+i] & rg[i]);
        assign c[k*GROUP+i] = rc[i];
      end

      assign gg[k] = rg[GROUP];
      assign gp[k] = &p[k*GROUP +: GROUP];
    end

    // Group carries as flat sum-of-products over group G/P, so no carry
    // has to ripple through earlier groups.
    assign gc[0] = hci[h];
    for (genvar k = 1; k <= NG; k++) begin : g_look
      logic [k:0] t;
      for (genvar j = 0; j < k; j++) begin : g_term
        if (j + 1 < k) begin : g_mid
          assign t[j] = gg[j] & (&gp[k-1:j+1]);
        end else begin : g_top
          assign t[j] = gg[j];
        end
      end
      assign t[k]  = hci[h] & (&gp[k-1:0]);
      assign gc[k] = |t;
    end

    assign hs[h]  = p ^ c;
    assign hco[h] = gc[NG];
  end

  // Handshake: stage 1 advances when stage 2 is empty or draining
  logic adv2;
  logic accept;

  assign adv2         = vld_p1 & (~vld_p2 | bus.out_ready);
  assign bus.in_ready = ~vld_p1 | ~vld_p2 | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;

  // Stage-valid flags; reset discards anything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (accept)
        vld_p1 <= 1'b1;
      else if (adv2)
        vld_p1 <= 1'b0;

      if (adv2)
        vld_p2 <= 1'b1;
      else if (bus.out_ready)
        vld_p2 <= 1'b0;
    end
  end

  // ---- stage 0 -> stage 1 boundary ----
  // Lower half-sum, mid carry and upper operand bits (MSBs are the sign bits)
  always_ff @(posedge clk) begin
    if (accept) begin
      sum_lo_p1 <= hs[0];
      c_mid_p1  <= hco[0];
      a_hi_p1   <= bus.a[WIDTH-1:H];
      b_hi_p1   <= bx[WIDTH-1:H];
    end
  end

  // ---- stage 1 -> stage 2 boundary ----
  // Result register; cleared by reset so the outputs read zero during rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_p2  <= '0;
      cout_p2 <= 1'b0;
    end else if (adv2) begin
      sum_p2  <= {hs[1], sum_lo_p1};
      cout_p2 <= hco[1];
    end
  end

`ifdef CLA_OVF_EN
  logic ovf_p2;
  logic ovf_d;

  assign ovf_d = (a_hi_p1[H-1] == b_hi_p1[H-1]) && (hs[1][H-1] != a_hi_p1[H-1]);

  // Signed overflow, registered alongside the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_p2 <= 1'b0;
    else if (adv2)
      ovf_p2 <= ovf_d;
  end

  assign bus.ovf = ovf_p2;
`endif

  assign bus.out_valid = vld_p2;
  assign bus.sum       = sum_p2;
  assign bus.cout      = cout_p2;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder (WIDTH=16, GROUP=4).
// Reference results come from plain integer arithmetic; a queue orders
// expected results by accepted transfer.
module tb_pipelined_cla_adder;

  localparam int W = 16;
  localparam int G = 4;

  typedef struct packed {
    logic         o;
    logic         c;
    logic [W-1:0] s;
  } res_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipelined_cla_adder_if #(.WIDTH(W)) bus ();

  pipelined_cla_adder #(.WIDTH(W), .GROUP(G)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  res_t q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   delivered = 0;

  function automatic longint sval(logic [W-1:0] v);
    return v[W-1] ? (longint'(v) - (longint'(1) << W)) : longint'(v);
  endfunction

  function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic sub);
    res_t   r;
    longint full;
    longint sfull;
    if (sub) begin
      full  = longint'(a) - longint'(b);
      r.c   = (a >= b);
      sfull = sval(a) - sval(b);
    end else begin
      full  = longint'(a) + longint'(b) + longint'(cin);
      r.c   = (full >= (longint'(1) << W));
      sfull = sval(a) + sval(b) + longint'(cin);
    end
    r.s = full[W-1:0];
    r.o = (sfull > ((longint'(1) << (W-1)) - 1)) || (sfull < -(longint'(1) << (W-1)));
`ifndef CLA_OVF_EN
    r.o = 1'b0;
`endif
    return r;
  endfunction

  function automatic res_t obs_res();
    res_t r;
    r.s = bus.sum;
    r.c = bus.cout;
`ifdef CLA_OVF_EN
    r.o = bus.ovf;
`else
    r.o = 1'b0;
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: record transfers seen just before the edge, then advance
  task automatic step();
    logic acc;
    logic del;
    res_t e;
    #1;
    acc = bus.in_valid && bus.in_ready;
    del = bus.out_valid && bus.out_ready;
    if (del) begin
      if (q.size() == 0) begin
        chk("spurious_out", bus.out_valid, 0);
      end else begin
        e = q.pop_front();
        delivered++;
        chk("result", obs_res(), e);
      end
    end
    if (acc) q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12 && q.size() > 0; i++) step();
    chk("drain_empty", q.size(), 0);
  endtask

  // Directed vector into an empty pipe, with explicit latency and value checks
  task automatic dir(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                     input logic sub, input logic [W-1:0] es, input logic ec,
                     input logic eo, input string tag);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    chk({tag, "_lat1"}, bus.out_valid, 0);
    step();
    chk({tag, "_lat2"}, bus.out_valid, 1);
    chk({tag, "_sum"}, bus.sum, es);
    chk({tag, "_cout"}, bus.cout, ec);
`ifdef CLA_OVF_EN
    chk({tag, "_ovf"}, bus.ovf, eo);
`else
    if (eo) checks += 0;
`endif
    step();
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(W-1){1'b1}}};
      3:       return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    res_t held;
    int   d0;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout", bus.cout, 0);
`ifdef CLA_OVF_EN
    chk("rst_ovf", bus.ovf, 0);
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_in_ready", bus.in_ready, 1);
    step();

    // Directed corner cases
    dir(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "cross_group");
    dir(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, "wrap");
    dir(16'h00FF, 16'hFF01, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "half_carry");
    dir(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
    dir(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, "sub_noborrow");
    dir(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_pos");
    dir(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "ovf_sub");

    // Random traffic with random backpressure
    for (int n = 0; n < 300; n++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.a         = pick();
      bus.b         = pick();
      bus.cin       = 1'($urandom_range(0, 1));
      bus.sub       = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    // Backpressure: three back-to-back sets with the sink stalled
    d0 = delivered;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0; bus.sub = 1'b0;
    step();
    bus.a = 16'h3333; bus.b = 16'h0100; bus.cin = 1'b1; bus.sub = 1'b0;
    step();
    bus.a = 16'h0010; bus.b = 16'h0020; bus.cin = 1'b0; bus.sub = 1'b1;
    chk("bp_in_ready_low", bus.in_ready, 0);
    chk("bp_out_valid", bus.out_valid, 1);
    chk("bp_first_sum", bus.sum, 16'h3333);
    held = obs_res();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold", obs_res(), held);
      chk("bp_hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 12 && q.size() > 0; i++) step();
    chk("bp_count", delivered - d0, 3);
    chk("bp_empty", q.size(), 0);

    // Reset with operations in flight
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a = 16'h1234; bus.b = 16'h1111; bus.cin = 1'b0; bus.sub = 1'b0;
    step();
    bus.a = 16'h4321; bus.b = 16'h0101;
    step();
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", bus.out_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_sum", bus.sum, 0);
    chk("mid_rst_cout", bus.cout, 0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_no_ghost", bus.out_valid, 0);
    end

    // Short random burst after reset, then final drain
    for (int n = 0; n < 40; n++) begin
      bus.in_valid  = 1'b1;
      bus.a         = pick();
      bus.b         = pick();
      bus.cin       = 1'($urandom_range(0, 1));
      bus.sub       = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 1) != 0);
      step();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width; legal values are multiples of 8 and at least 8.
REQ-002 SHALL have parameter GROUP, default 4, bits per carry-lookahead group; WIDTH/2 SHALL be a multiple of GROUP.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand set presented.
REQ-006 SHALL have port in_ready  output  1  block accepts an operand set this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry-in; used only when sub=0.
REQ-010 SHALL have port sub  input  1  mode select: 0 = add, 1 = subtract (A-B).
REQ-011 SHALL have port out_valid  output  1  result presented.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-013 SHALL have port sum  output  WIDTH  result.
REQ-014 SHALL have port cout  output  1  carry-out of the MSB.
REQ-015 SHALL have port ovf  output  1  signed overflow; present only with CLA_OVF_EN.

Function
REQ-016 SHALL compute {cout,sum} = A + B' + c0, where B' = sub ? ~B : B and c0 = sub ? 1 : cin.
REQ-017 SHALL use GROUP-bit lookahead groups: per-bit g=a&b', p=a^b'; group carries from group G/P, not from a ripple chain across groups.
REQ-018 Stage 1 SHALL register the lower half-sum (bits WIDTH/2-1:0), the carry into bit WIDTH/2, the upper-half a/b' bits and the a/b' sign bits.
REQ-019 Stage 2 SHALL compute the upper half using the registered carry and register sum, cout and ovf.
REQ-020 A transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; a transfer out SHALL occur where out_valid and out_ready are both 1.
REQ-021 Latency SHALL be exactly 2 cycles from an input transfer to out_valid=1 when no backpressure is applied; throughput SHALL be one result per cycle.
REQ-022 in_ready SHALL be 1 when stage 1 is empty, or when stage 1 can move into stage 2 in the same cycle (stage 2 empty or out_ready=1); in_ready SHALL NOT depend on in_valid.
REQ-023 While out_valid=1 and out_ready=0, sum, cout and ovf SHALL hold stable and no held data SHALL be overwritten or lost.
REQ-024 Bubbles SHALL be collapsed: an empty stage 2 SHALL load from a valid stage 1 regardless of out_ready.
REQ-025 Wrap-around: the all-ones + all-ones + 1 add SHALL give sum all-ones with cout=1; cout SHALL always be the true (WIDTH+1)-th bit.
REQ-026 In subtract mode, cout=1 SHALL mean no borrow (A >= B unsigned).
REQ-027 Operand values SHALL be sampled only on an accepted transfer; a, b, cin and sub SHALL be don't-care otherwise.

Reset
REQ-028 Asserting rst SHALL immediately clear both stage-valid flags, giving out_valid=0, with no clock edge required.
REQ-029 While rst is asserted, sum=0, cout=0 and ovf=0 SHALL hold.
REQ-030 Operations in flight when rst asserts SHALL be discarded and never appear at the output.
REQ-031 in_ready SHALL read 1 on the first cycle after rst deasserts.

Configuration
REQ-032 Macro CLA_OVF_EN defined: port ovf SHALL exist and equal (a[MSB]==b'[MSB]) && (sum[MSB]!=a[MSB]), registered with the result.
REQ-033 Macro CLA_OVF_EN undefined: port ovf and its pipeline registers SHALL be absent; all other behaviour SHALL be identical.

Verification (WIDTH=16, GROUP=4)
REQ-034 Cross-group carry: a=0x00FF, b=0x0001, cin=0, sub=0 -> 2 cycles later sum=0x0100, cout=0.
REQ-035 Wrap-around: a=0xFFFF, b=0xFFFF, cin=1, sub=0 -> sum=0xFFFF, cout=1; half-boundary carry: a=0x00FF, b=0xFF01, cin=0 -> sum=0x0000, cout=1.
REQ-036 Subtract: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0; with CLA_OVF_EN, a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1.
REQ-037 Backpressure: stream 3 back-to-back operand sets with out_ready=0 -> in_ready drops after 2 accepts, the first result holds stable; out_ready=1 -> all 3 results emerge in order, none lost or duplicated.
REQ-038 Reset mid-operation: assert rst one cycle after an input transfer -> out_valid=0 and sum=0 immediately; after release, that result never appears and in_ready=1.
